// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive front-end and the TX clock divider.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;

  function automatic int uart_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input; RST_VAL sets the idle level held in reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its midpoint and pushes good
// bytes into the rx FIFO, flagging framing and overrun errors as one-cycle pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | timing half a bit to the start-bit midpoint, rejecting glitches
// DATA      | sampling 8 data bits LSB-first, one per DIV cycles
// STOP      | sampling the stop bit and deciding write / overrun / framing error
// WAIT_HIGH | after a framing error, holding off until the line returns high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int UART_BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       full,
  output logic [7:0] data,
  output logic       write,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV  = uart_div(CLK_FREQ, UART_BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx: CLK_FREQ/UART_BAUD must be at least 4");
  end

  logic           rx_s;
  uart_rx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shreg, shreg_n;
  logic [7:0]     data_n;
  logic           write_n, frame_err_n, overrun_n;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      write     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      write     <= write_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = data;
    write_n     = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        if (cnt == CW'(HALF - 1)) begin
          // Line back high at the start-bit midpoint means it was noise.
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            state_n = IDLE;
            if (full) overrun_n = 1'b1;
            else      write_n   = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV = 16 (1 MHz clock, 62.5 kbaud).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic [7:0] data;
  logic       write;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int n_write = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_multi = 0;
  int last_wcyc = 0;
  logic [7:0] wq[$];

  uart_rx #(.CLK_FREQ(1_000_000), .UART_BAUD(62_500)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .full      (full),
    .data      (data),
    .write     (write),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      n_write++;
      wq.push_back(data);
      last_wcyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    if ((write === 1'b1 && frame_err === 1'b1) || (write === 1'b1 && overrun === 1'b1) ||
        (frame_err === 1'b1 && overrun === 1'b1))
      n_multi++;
  end

  // Drives one frame at 16 clocks per bit starting on a falling edge; t0 is the cycle stamp at start.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    t0 = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_write(output logic [7:0] v, output logic ok);
    ok = (wq.size() > 0);
    v  = ok ? wq.pop_front() : 8'hxx;
  endtask

  task automatic test_reset();
    int busy_seen;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", data); end
    compared++; if (write !== 1'b0) begin mismatched++; $display("FAIL reset_write got %b want 0", write); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun got %b want 0", overrun); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    compared++; if (busy_seen != 0) begin mismatched++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_basic();
    int t0, w0, f0, o0, lat;
    logic [7:0] v;
    logic ok;
    w0 = n_write; f0 = n_ferr; o0 = n_ovr;
    send_byte(8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    compared++; if (n_write - w0 != 1) begin mismatched++; $display("FAIL a5_write_count got %0d want 1", n_write - w0); end
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'hA5) begin mismatched++; $display("FAIL a5_data got %h want a5", v); end
    lat = last_wcyc - t0;
    compared++; if (lat < 155 || lat > 157) begin mismatched++; $display("FAIL a5_latency got %0d want 155..157", lat); end
    compared++; if (n_ferr != f0 || n_ovr != o0) begin mismatched++; $display("FAIL a5_err_pulses got ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL a5_busy_after got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int w0, f0, rose;
    w0 = n_write; f0 = n_ferr; rose = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    if (busy === 1'b1) rose = 1;
    rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) rose = 1;
    end
    compared++; if (rose != 1) begin mismatched++; $display("FAIL glitch_busy_rise got %0d want 1", rose); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy_fall got %b want 0", busy); end
    repeat (20) @(negedge clk);
    compared++; if (n_write != w0 || n_ferr != f0) begin mismatched++; $display("FAIL glitch_pulses got wr %0d ferr %0d want 0 0", n_write - w0, n_ferr - f0); end
  endtask

  task automatic test_frame_err();
    int t0, w0, f0;
    logic [7:0] v;
    logic ok;
    w0 = n_write; f0 = n_ferr;
    send_byte(8'h00, 1'b0, t0);
    repeat (64) @(negedge clk);
    compared++; if (n_ferr - f0 != 1) begin mismatched++; $display("FAIL ferr_count got %0d want 1", n_ferr - f0); end
    compared++; if (n_write != w0) begin mismatched++; $display("FAIL ferr_write got %0d want 0", n_write - w0); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ferr_busy_break got %b want 1", busy); end
    compared++; if (data !== 8'hA5) begin mismatched++; $display("FAIL ferr_data_held got %h want a5", data); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    repeat (10) @(negedge clk);
    send_byte(8'h5A, 1'b1, t0);
    repeat (4) @(negedge clk);
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'h5A) begin mismatched++; $display("FAIL ferr_next_data got %h want 5a", v); end
  endtask

  task automatic test_overrun();
    int t0, w0, o0;
    logic [7:0] v;
    logic ok;
    w0 = n_write; o0 = n_ovr;
    full = 1'b1;
    send_byte(8'h3C, 1'b1, t0);
    repeat (4) @(negedge clk);
    full = 1'b0;
    compared++; if (n_ovr - o0 != 1) begin mismatched++; $display("FAIL ovr_count got %0d want 1", n_ovr - o0); end
    compared++; if (n_write != w0) begin mismatched++; $display("FAIL ovr_write got %0d want 0", n_write - w0); end
    compared++; if (data !== 8'h3C) begin mismatched++; $display("FAIL ovr_data got %h want 3c", data); end
    repeat (10) @(negedge clk);
    send_byte(8'h3D, 1'b1, t0);
    repeat (4) @(negedge clk);
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'h3D) begin mismatched++; $display("FAIL ovr_next_data got %h want 3d", v); end
  endtask

  task automatic test_back_to_back();
    int t0, w0, f0, o0;
    logic [7:0] v;
    logic ok;
    logic [7:0] third;
    third = 8'h55;
    w0 = n_write; f0 = n_ferr; o0 = n_ovr;
    send_byte(8'h30, 1'b1, t0);
    send_byte(8'h31, 1'b1, t0);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = third[i];
      repeat (16) @(negedge clk);
    end
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_reset_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    compared++; if (n_write - w0 != 2) begin mismatched++; $display("FAIL b2b_write_count got %0d want 2", n_write - w0); end
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'h30) begin mismatched++; $display("FAIL b2b_first got %h want 30", v); end
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'h31) begin mismatched++; $display("FAIL b2b_second got %h want 31", v); end
    compared++; if (n_ferr != f0 || n_ovr != o0) begin mismatched++; $display("FAIL b2b_abort_pulses got ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0); end
    send_byte(8'h7E, 1'b1, t0);
    repeat (4) @(negedge clk);
    pop_write(v, ok);
    compared++; if (!ok || v !== 8'h7E) begin mismatched++; $display("FAIL b2b_after_reset got %h want 7e", v); end
    compared++; if (n_multi != 0) begin mismatched++; $display("FAIL pulse_exclusive got %0d overlaps want 0", n_multi); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    repeat (10) @(negedge clk);
    test_glitch();
    test_frame_err();
    repeat (10) @(negedge clk);
    test_overrun();
    repeat (10) @(negedge clk);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
